// File: rtl/key_router_pkg.sv
// Shared definitions for the key router: FSM state encoding, default timing
// constants and a small helper used to size the shared counter.
package key_router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DB_PRESS = 3'd1,
    ST_HELD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_DB_REL   = 3'd4
  } state_e;

  localparam int DEF_N_CH    = 3;
  localparam int DEF_SEL_W   = 2;
  localparam int DEF_DEB_CYC = 16;
  localparam int DEF_REP_DLY = 64;
  localparam int DEF_REP_PER = 16;

  // Largest of three timing constants; the shared counter must cover all of them.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw push-key. Resets to 1 so a key is seen as
// released until two clean samples have passed through after reset.
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/key_router_n.sv
// Debounced push-key with auto-repeat, routed to one of N_CH channels chosen
// by sel at the moment the press is accepted. One shared counter serves the
// press debounce, repeat delay, repeat period and release debounce.
module key_router_n
  import key_router_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             repeat_en,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  level,
  output logic             busy
);

  localparam int CNT_MAX = max3(DEB_CYC, REP_DLY, REP_PER);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);
  localparam logic [SEL_W:0]   N_CH_V   = (SEL_W + 1)'(N_CH);

  // Reject parameter sets the design cannot honour.
  if (SEL_W < 1) begin : g_bad_sel_w
    $error("key_router_n: SEL_W must be >= 1");
  end
  if (N_CH < 1 || N_CH > (1 << SEL_W)) begin : g_bad_n_ch
    $error("key_router_n: N_CH must be in 1..2**SEL_W");
  end
  if (DEB_CYC < 1 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_timing
    $error("key_router_n: DEB_CYC, REP_DLY and REP_PER must be >= 1");
  end

  logic             key_s;
  logic             pressed;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             ch_ok_q, ch_ok_d;
  logic             fire;
  logic [N_CH-1:0]  pulse_d, level_d;
  logic [N_CH-1:0]  pulse_q, level_q;

  key_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (key_n),
    .sync_out (key_s)
  );

  assign pressed = ~key_s;

  // State, counter, latched channel and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      ch_ok_q <= 1'b0;
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      ch_ok_q <= ch_ok_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state logic; release always takes priority over a repeat expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    ch_ok_d = ch_ok_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_DB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          ch_d    = sel;
          ch_ok_d = ({1'b0, sel} < N_CH_V);
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_DB_REL;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!pressed) begin
          state_d = ST_DB_REL;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DB_REL: begin
        if (pressed) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-hot output decode from the upcoming state; an out-of-range channel
  // leaves every bit low for the whole press.
  always_comb begin
    pulse_d = '0;
    level_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      pulse_d[i] = fire && ch_ok_d && (ch_d == SEL_W'(i));
      level_d[i] = ch_ok_d && (ch_d == SEL_W'(i)) &&
                   (state_d == ST_HELD || state_d == ST_REPEAT || state_d == ST_DB_REL);
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/key_router_n.md
KEY_ROUTER_N -- requirements
Module: key_router_n

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of output channels, 1..2**SEL_W.
REQ-002 SHALL have parameter SEL_W, default 2: width of sel.
REQ-003 SHALL have parameter DEB_CYC, default 16: debounce length in cycles, >=1.
REQ-004 SHALL have parameter REP_DLY, default 64: auto-repeat start delay in cycles, >=1.
REQ-005 SHALL have parameter REP_PER, default 16: auto-repeat period in cycles, >=1.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port key_n  input  1  raw asynchronous push-key, low = pressed.
REQ-009 SHALL have port sel  input  SEL_W  target channel select.
REQ-010 SHALL have port repeat_en  input  1  enables auto-repeat while held.
REQ-011 SHALL have port pulse  output  N_CH  one-cycle press/repeat strobe per channel.
REQ-012 SHALL have port level  output  N_CH  debounced held level per channel.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL pass key_n through a 2-flop synchronizer; pressed = inverted synchronizer output.
REQ-015 SHALL implement FSM states IDLE, DB_PRESS, HELD, REPEAT, DB_REL with one shared counter cnt, counter width = clog2(max(DEB_CYC, REP_DLY, REP_PER)).
REQ-016 IDLE: pressed -> DB_PRESS, cnt=0; else stay.
REQ-017 DB_PRESS: not pressed -> IDLE, no output; cnt==DEB_CYC-1 while pressed -> HELD, cnt=0, latch sel into ch_q, assert pulse[ch_q] for one cycle; else cnt+1.
REQ-018 Latency: with key_n stable low, edge 0 = first edge sampling key_n low; pulse SHALL be high in the cycle following edge 2+DEB_CYC.
REQ-019 HELD: level[ch_q]=1; not pressed -> DB_REL, cnt=0; repeat_en high and cnt==REP_DLY-1 -> REPEAT, cnt=0, pulse[ch_q]; else cnt+1. While repeat_en is low, cnt holds 0.
REQ-020 REPEAT: level[ch_q]=1; not pressed -> DB_REL, cnt=0; repeat_en low -> HELD, cnt=0, no pulse; cnt==REP_PER-1 -> pulse[ch_q], cnt=0; else cnt+1.
REQ-021 DB_REL: level[ch_q] stays 1; pressed -> HELD, cnt=0, no new pulse; cnt==DEB_CYC-1 while released -> IDLE, level cleared next cycle; else cnt+1.
REQ-022 sel SHALL be sampled only on DB_PRESS->HELD; sel changes in any other state SHALL be ignored until the next press.
REQ-023 sel >= N_CH at latch time SHALL make the whole press inert: FSM runs normally, all pulse and level bits stay 0.
REQ-024 At most one bit of pulse and one bit of level SHALL be high in any cycle; pulse and level SHALL be registered outputs.
REQ-025 Release and repeat expiry in the same cycle: release wins, no pulse.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, cnt=0, ch_q=0, synchronizer flops=1 (released), pulse=0, level=0, busy=0.
REQ-027 Reset mid-press SHALL discard the press; a key still held after reset deasserts SHALL undergo a full fresh debounce and produce one new pulse.

Structure
REQ-028 State encodings and default timing constants SHALL live in shared package key_router_pkg.
REQ-029 The synchronizer SHALL be sub-module key_sync (2-flop, reset to 1); FSM, counter and output decode SHALL stay in key_router_n.
REQ-030 Illegal parameter values (N_CH > 2**SEL_W, any timing <1) SHALL be rejected at elaboration.

Verification
REQ-031 DEB_CYC=4, sel=1, key_n low at edge 0 and held -> pulse=3'b010 for exactly one cycle after edge 6; level=3'b010 from then until release plus debounce.
REQ-032 Bounce: key_n low for 2 cycles, then high -> no pulse; level stays 0; FSM returns to IDLE.
REQ-033 repeat_en=1, REP_DLY=8, REP_PER=4, DEB_CYC=4, key held 30 cycles -> first pulse, then pulses 8, 12, 16, 20 ... cycles after the first, until release.
REQ-034 sel changed 1->2 while held -> pulse and level remain on channel 1; next press uses channel 2.
REQ-035 sel=3 with N_CH=3 -> full press and release produce pulse=0 and level=0; busy toggles normally.
REQ-036 rst_n low for one edge while in HELD with key held -> outputs 0 next cycle; exactly one new pulse 2+DEB_CYC edges after reset releases.
